// File: rtl/icache_mem_arb.sv
//------------------------------------------------------------------------------
// Module   : icache_mem_arb
// Brief    : Round-robin refill arbiter from NUM_PORTS icache miss ports onto a
//            single multi-beat line-refill memory port. Define
//            ICACHE_MEM_ARB_PERF_EN to add refill/stall performance counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module icache_mem_arb #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            req_valid_i,
  output logic [NUM_PORTS-1:0]            req_ready_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS-1:0]            kill_i,
  output logic [NUM_PORTS-1:0]            rsp_valid_o,
  output logic [BEATS*DATA_WIDTH-1:0]     rsp_data_o,
  output logic                            mem_req_valid_o,
  input  logic                            mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr_o,
  input  logic                            mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]           mem_rsp_data_i
`ifdef ICACHE_MEM_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_refill_cnt_o,
  output logic [31:0]                     perf_stall_cnt_o
`endif
);

  localparam int PW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW          = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_W      = BEATS * DATA_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_W / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           owner_q, owner_d;
  logic [PW-1:0]           rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    kill_q, kill_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    mem_req_valid_q, mem_req_valid_d;
  logic                    rsp_pulse_q, rsp_pulse_d;

  logic                    grant_found;
  logic [PW-1:0]           grant_idx;
  logic [PW-1:0]           cand;

  // Scan from the port after the last owner so every requester is reached
  // within NUM_PORTS-1 refills.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(rr_q) + i) % NUM_PORTS);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state_q == S_IDLE && grant_found) begin
      req_ready_o = NUM_PORTS'(1) << grant_idx;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_d            = rr_q;
    addr_d          = addr_q;
    kill_d          = kill_q;
    cnt_d           = cnt_q;
    line_d          = line_q;
    mem_req_valid_d = 1'b0;
    rsp_pulse_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          owner_d         = grant_idx;
          rr_d            = grant_idx;
          addr_d          = req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] & ALIGN_MASK;
          kill_d          = kill_i[grant_idx];
          mem_req_valid_d = 1'b1;
          state_d         = S_REQ;
        end
      end
      S_REQ: begin
        if (kill_i[owner_q]) kill_d = 1'b1;
        mem_req_valid_d = 1'b1;
        if (mem_req_ready_i) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = '0;
          state_d         = S_DATA;
        end
      end
      S_DATA: begin
        if (kill_i[owner_q]) kill_d = 1'b1;
        if (mem_rsp_valid_i) begin
          line_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = mem_rsp_data_i;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BEATS - 1)) begin
            rsp_pulse_d = !kill_d;
            state_d     = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      owner_q         <= '0;
      rr_q            <= PW'(NUM_PORTS - 1);
      addr_q          <= '0;
      kill_q          <= 1'b0;
      cnt_q           <= '0;
      line_q          <= '0;
      mem_req_valid_q <= 1'b0;
      rsp_pulse_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      rr_q            <= rr_d;
      addr_q          <= addr_d;
      kill_q          <= kill_d;
      cnt_q           <= cnt_d;
      line_q          <= line_d;
      mem_req_valid_q <= mem_req_valid_d;
      rsp_pulse_q     <= rsp_pulse_d;
    end
  end

  // A kill arriving in the response cycle itself still cancels the pulse.
  always_comb begin
    rsp_valid_o = '0;
    if (state_q == S_RESP && rsp_pulse_q && !kill_i[owner_q]) begin
      rsp_valid_o = NUM_PORTS'(1) << owner_q;
    end
  end

  assign rsp_data_o      = line_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = addr_q;

`ifdef ICACHE_MEM_ARB_PERF_EN
  logic [31:0] refill_cnt_q, refill_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    refill_cnt_d = refill_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (state_d == S_RESP && state_q != S_RESP && refill_cnt_q != 32'hFFFF_FFFF) begin
      refill_cnt_d = refill_cnt_q + 32'd1;
    end
    if ((|req_valid_i) && !(|req_ready_o) && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      refill_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      refill_cnt_q <= refill_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign perf_refill_cnt_o = refill_cnt_q;
  assign perf_stall_cnt_o  = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_mem_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_icache_mem_arb
// Brief    : Directed self-checking bench for icache_mem_arb (2 ports, 4x64b).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_icache_mem_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [127:0] req_addr = '0;
  logic [1:0]   kill = '0;
  logic [1:0]   rsp_valid;
  logic [255:0] rsp_data;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [63:0]  mem_req_addr;
  logic         mem_rsp_valid = 1'b0;
  logic [63:0]  mem_rsp_data = '0;
`ifdef ICACHE_MEM_ARB_PERF_EN
  logic [31:0]  perf_refill;
  logic [31:0]  perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  icache_mem_arb dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .kill_i          (kill),
    .rsp_valid_o     (rsp_valid),
    .rsp_data_o      (rsp_data),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_data_i  (mem_rsp_data)
`ifdef ICACHE_MEM_ARB_PERF_EN
    ,
    .perf_refill_cnt_o (perf_refill),
    .perf_stall_cnt_o  (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] exp_line(input logic [63:0] m);
    return {m * 64'd4, m * 64'd3, m * 64'd2, m};
  endfunction

  // Beat b of a refill carries m*(b+1); kill value kv is driven during beat kb.
  task automatic feed(input logic [63:0] m, input int kb, input logic [1:0] kv);
    for (int b = 0; b < 4; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = m * 64'(b + 1);
      kill          = (b == kb) ? kv : 2'b00;
      step();
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    kill          = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0; kill = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Single uncontended refill starting in IDLE.
  task automatic refill(input int p, input logic [63:0] addr, input logic [63:0] aligned,
                        input logic [63:0] m);
    logic [1:0] oh;
    oh = 2'b01 << p;
    req_valid = oh;
    req_addr[p*64 +: 64] = addr;
    mem_req_ready = 1'b1;
    #1;
    chk("refill_ready", req_ready, oh);
    step();
    req_valid = '0;
    chk("refill_mreq_valid", mem_req_valid, 1);
    chk("refill_mreq_addr", mem_req_addr, aligned);
    step();
    feed(m, -1, 2'b00);
    chk("refill_rsp_valid", rsp_valid, oh);
    chk("refill_rsp_data", rsp_data, exp_line(m));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp_g;
    logic [63:0] m;

    // Reset state
    apply_reset();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mreq_valid", mem_req_valid, 0);
    chk("rst_mreq_addr", mem_req_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // Single request on port 0; a stray beat in REQ must be ignored
    req_valid = 2'b01;
    req_addr[63:0] = 64'h0000_0000_1000_0234;
    mem_req_ready = 1'b1;
    #1;
    chk("t1_ready_c0", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    chk("t1_mreq_valid_c1", mem_req_valid, 1);
    chk("t1_mreq_addr_c1", mem_req_addr, 64'h0000_0000_1000_0220);
    step();
    chk("t1_mreq_valid_c2", mem_req_valid, 0);
    feed(64'h1111_1111_1111_1111, -1, 2'b00);
    chk("t1_rsp_valid_c6", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    step();
    chk("t1_rsp_valid_c7", rsp_valid, 2'b00);
    chk("t1_rsp_data_hold", rsp_data,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Continuous contention: grants alternate 0,1,0,1; a non-owner kill is ignored
    apply_reset();
    req_addr[63:0]   = 64'h0000_0000_1000_0234;
    req_addr[127:64] = 64'h0000_0000_2000_0047;
    req_valid = 2'b11;
    mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      m = 64'h0101_0101_0101_0101 * 64'(k + 2);
      #1;
      chk("t2_grant", req_ready, exp_g);
      step();
      chk("t2_mreq_addr", mem_req_addr,
          (k % 2 == 0) ? 64'h0000_0000_1000_0220 : 64'h0000_0000_2000_0040);
      chk("t2_ready_busy", req_ready, 2'b00);
      step();
      feed(m, (k == 0) ? 1 : -1, 2'b10);
      chk("t2_rsp_valid", rsp_valid, exp_g);
      chk("t2_rsp_data", rsp_data, exp_line(m));
      step();
    end
    req_valid = 2'b00;

    // Memory stalls the request for 5 cycles
    req_valid = 2'b10;
    mem_req_ready = 1'b0;
    #1;
    chk("t3_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_mreq_valid_hold", mem_req_valid, 1);
      chk("t3_mreq_addr_hold", mem_req_addr, 64'h0000_0000_2000_0040);
      chk("t3_ready_blocked", req_ready, 2'b00);
      step();
    end
    req_valid = 2'b00;
    mem_req_ready = 1'b1;
    step();
    feed(64'h0000_0000_CAFE_0001, -1, 2'b00);
    chk("t3_rsp_valid", rsp_valid, 2'b10);
    chk("t3_rsp_data", rsp_data, exp_line(64'h0000_0000_CAFE_0001));
    step();

    // Owner kill during beat 2 suppresses the response; pending port 1 follows
    req_valid = 2'b11;
    #1;
    chk("t4_grant0", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    step();
    feed(64'h0505_0505_0505_0505, 2, 2'b01);
    chk("t4_rsp_killed", rsp_valid, 2'b00);
    chk("t4_ready_in_resp", req_ready, 2'b00);
    step();
    #1;
    chk("t4_grant1_next", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("t4_mreq_addr1", mem_req_addr, 64'h0000_0000_2000_0040);
    step();
    feed(64'h0707_0707_0707_0707, -1, 2'b00);
    chk("t4_rsp_valid1", rsp_valid, 2'b10);
    chk("t4_rsp_data1", rsp_data, exp_line(64'h0707_0707_0707_0707));
    step();

    // Asynchronous reset during beat 1
    req_valid = 2'b01;
    #1;
    chk("t5_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 64'h9999_0000_9999_0000;
    step();
    mem_rsp_data = 64'h9999_1111_9999_1111;
    req_valid = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", req_ready, 2'b00);
    chk("t5_rst_rsp_valid", rsp_valid, 2'b00);
    chk("t5_rst_mreq_valid", mem_req_valid, 0);
    chk("t5_rst_mreq_addr", mem_req_addr, 0);
    chk("t5_rst_rsp_data", rsp_data, 0);
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    req_valid = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    step();
    refill(1, 64'h0000_0000_3000_001F, 64'h0000_0000_3000_0000, 64'h0000_0ABC_0000_0ABC);

`ifdef ICACHE_MEM_ARB_PERF_EN
    // 3 refills with exactly 2 stall cycles
    apply_reset();
    chk("perf_rst_refill", perf_refill, 0);
    chk("perf_rst_stall", perf_stall, 0);
    req_valid = 2'b01;
    req_addr[63:0] = 64'h0000_0000_4000_0000;
    mem_req_ready = 1'b0;
    #1;
    chk("perf_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    step();
    step();
    req_valid = 2'b00;
    mem_req_ready = 1'b1;
    step();
    feed(64'h0000_0000_0000_0011, -1, 2'b00);
    chk("perf_rsp_valid", rsp_valid, 2'b01);
    step();
    refill(1, 64'h0000_0000_5000_0008, 64'h0000_0000_5000_0000, 64'h0000_0000_0000_0022);
    refill(0, 64'h0000_0000_6000_0010, 64'h0000_0000_6000_0000, 64'h0000_0000_0000_0033);
    chk("perf_refill_cnt", perf_refill, 3);
    chk("perf_stall_cnt", perf_stall, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
